// File: rtl/kim_display_keypad.sv
// KIM-1 board model: 74145 select decode, 6-digit LED display with afterglow,
// and a debounced 3x7 keypad matrix returned on port A.

module kim_digit_cell #(
  parameter int PERSIST_CYCLES = 4096,
  parameter int PCW            = $clog2(PERSIST_CYCLES + 1)
) (
  input  logic       phi2,
  input  logic       rst,
  input  logic       sel_hit,
  input  logic [6:0] seg_in,
  output logic [6:0] seg,
  output logic       lit
);
  logic [PCW-1:0] cnt;

  // Counter reaching 1 marks the final afterglow edge; blank on that edge.
  always_ff @(posedge phi2) begin
    if (rst) begin
      cnt <= '0;
      seg <= '0;
      lit <= 1'b0;
    end else if (sel_hit) begin
      cnt <= PCW'(PERSIST_CYCLES);
      seg <= seg_in;
      lit <= 1'b1;
    end else if (cnt > PCW'(1)) begin
      cnt <= cnt - PCW'(1);
    end else if (cnt == PCW'(1)) begin
      cnt <= '0;
      seg <= '0;
      lit <= 1'b0;
    end
  end
endmodule

module kim_display_keypad #(
  parameter int NUM_DIGITS      = 6,
  parameter int PERSIST_CYCLES  = 4096,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic                    phi2,
  input  logic                    rst,
  input  logic [7:0]              PAO,
  input  logic [7:0]              DDRA,
  input  logic [7:0]              PBO,
  input  logic [7:0]              DDRB,
  input  logic [20:0]             keys,
  output logic [7:0]              PAI,
  output logic [NUM_DIGITS*7-1:0] digit_seg,
  output logic [NUM_DIGITS-1:0]   digit_lit,
  output logic                    key_any
);
  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [3:0]     sel;
  logic [6:0]     seg_in;
  logic [20:0]    ksync1, ksync, ksync_d, kdb;
  logic [DCW-1:0] dcnt;
  logic [6:0]     row_n;

  // Select lines only drive the 74145 when all four bits are outputs.
  assign sel    = (DDRB[4:1] == 4'hF) ? PBO[4:1] : 4'hF;
  assign seg_in = PAO[6:0] & DDRA[6:0];

  logic unused;
  assign unused = ^{PAO[7], DDRA[7], PBO[7:5], PBO[0], DDRB[7:5], DDRB[0]};

  always_ff @(posedge phi2) begin
    if (rst) begin
      ksync1  <= '0;
      ksync   <= '0;
      ksync_d <= '0;
      dcnt    <= '0;
      kdb     <= '0;
    end else begin
      ksync1  <= keys;
      ksync   <= ksync1;
      ksync_d <= ksync;
      if (ksync != ksync_d) begin
        dcnt <= '0;
      end else if (dcnt != DCW'(DEBOUNCE_CYCLES)) begin
        dcnt <= dcnt + DCW'(1);
        // Load only on the transition into saturation: once per stable run.
        if (dcnt == DCW'(DEBOUNCE_CYCLES - 1)) kdb <= ksync;
      end
    end
  end

  always_comb begin
    row_n = 7'h7F;
    case (sel)
      4'd0:    row_n = ~kdb[6:0];
      4'd1:    row_n = ~kdb[13:7];
      4'd2:    row_n = ~kdb[20:14];
      default: row_n = 7'h7F;
    endcase
  end

  always_ff @(posedge phi2) begin
    if (rst) begin
      PAI     <= 8'hFF;
      key_any <= 1'b0;
    end else begin
      PAI     <= {1'b1, row_n};
      key_any <= |kdb;
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    kim_digit_cell #(.PERSIST_CYCLES(PERSIST_CYCLES)) u_digit (
      .phi2   (phi2),
      .rst    (rst),
      .sel_hit(sel == 4'(d + 4)),
      .seg_in (seg_in),
      .seg    (digit_seg[d*7 +: 7]),
      .lit    (digit_lit[d])
    );
  end
endmodule

// File: tb/tb_kim_display_keypad.sv
// Directed plus randomized bench for kim_display_keypad against a timestamp-based model.

module tb_kim_display_keypad;
  localparam int ND  = 6;
  localparam int P   = 64;
  localparam int D   = 32;
  localparam int HN  = 8192;

  logic              phi2 = 1'b0;
  logic              rst;
  logic [7:0]        PAO, DDRA, PBO, DDRB;
  logic [20:0]       keys;
  logic [7:0]        PAI;
  logic [ND*7-1:0]   digit_seg;
  logic [ND-1:0]     digit_lit;
  logic              key_any;

  kim_display_keypad #(.NUM_DIGITS(ND), .PERSIST_CYCLES(P), .DEBOUNCE_CYCLES(D)) dut (
    .phi2(phi2), .rst(rst), .PAO(PAO), .DDRA(DDRA), .PBO(PBO), .DDRB(DDRB),
    .keys(keys), .PAI(PAI), .digit_seg(digit_seg), .digit_lit(digit_lit), .key_any(key_any)
  );

  always #5 phi2 = ~phi2;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: edge index, key sample history with start edge of each stable run,
  // and the edge at which each digit was last selected.
  int          n = 4;
  logic [20:0] kin_hist [HN];
  int          runst    [HN];
  logic [20:0] kdb_m;
  int          last_sel [ND];
  logic [6:0]  mseg     [ND];
  logic [7:0]      e_pai;
  logic            e_any;
  logic [ND*7-1:0] e_seg;
  logic [ND-1:0]   e_lit;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_edge();
    logic [3:0] s;
    n++;
    if (rst) begin
      kin_hist[n-1] = '0; kin_hist[n] = '0;
      runst[n-1] = n - 2; runst[n] = n - 2;
      kdb_m = '0;
      e_pai = 8'hFF;
      e_any = 1'b0;
      for (int d = 0; d < ND; d++) begin
        last_sel[d] = -1000000;
        mseg[d] = '0;
      end
    end else begin
      s = (DDRB[4:1] == 4'hF) ? PBO[4:1] : 4'hF;
      e_pai = {1'b1, (s < 4'd3) ? ~kdb_m[int'(s)*7 +: 7] : 7'h7F};
      e_any = |kdb_m;
      for (int d = 0; d < ND; d++)
        if (int'(s) == d + 4) begin
          last_sel[d] = n;
          mseg[d] = PAO[6:0] & DDRA[6:0];
        end
      kin_hist[n] = keys;
      runst[n] = (keys == kin_hist[n-1]) ? runst[n-1] : n;
      if (runst[n-2] + D + 2 == n) kdb_m = kin_hist[n-2];
    end
    for (int d = 0; d < ND; d++) begin
      e_lit[d] = (n - last_sel[d]) < P;
      e_seg[d*7 +: 7] = e_lit[d] ? mseg[d] : 7'h00;
    end
  endtask

  task automatic step();
    @(posedge phi2);
    model_edge();
    @(negedge phi2);
    chk("pai", PAI, e_pai);
    chk("seg", digit_seg, e_seg);
    chk("lit", digit_lit, e_lit);
    chk("key_any", key_any, e_any);
  endtask

  task automatic set_code(input logic [3:0] c);
    DDRB = 8'h1E;
    PBO  = {3'b000, c, 1'b0};
  endtask

  initial begin
    rst = 1'b1;
    PAO = 8'($urandom); DDRA = 8'($urandom); PBO = 8'($urandom); DDRB = 8'($urandom);
    keys = 21'($urandom);
    @(negedge phi2);

    // Reset
    step();
    chk("rst_pai", PAI, 8'hFF);
    chk("rst_seg", digit_seg, '0);
    chk("rst_lit", digit_lit, '0);
    chk("rst_any", key_any, 1'b0);
    step();

    // Digit capture and persistence
    rst = 1'b0; keys = '0;
    DDRB = 8'h1E; PBO = 8'h08; DDRA = 8'h7F; PAO = 8'h3F;
    step();
    chk("cap_seg", digit_seg[6:0], 7'h3F);
    chk("cap_lit", digit_lit[0], 1'b1);
    PBO = 8'h1E;
    for (int i = 1; i < P; i++) begin
      step();
      chk("glow_lit", digit_lit[0], 1'b1);
    end
    step();
    chk("blank_lit", digit_lit[0], 1'b0);
    chk("blank_seg", digit_seg[6:0], 7'h00);

    // Partial DDRA and refresh
    DDRA = 8'h0F; PAO = 8'h7F;
    for (int k = 0; k < 5; k++) begin
      set_code(4'd5);
      step();
      PBO = 8'h1E;
      chk("ref_seg", digit_seg[13:7], 7'h0F);
      chk("ref_lit", digit_lit[1], 1'b1);
      for (int i = 0; i < P - 2; i++) begin
        step();
        chk("ref_lit_hold", digit_lit[1], 1'b1);
      end
    end

    // Keypad read
    keys = 21'(1) << 9;
    for (int i = 0; i < D + 5; i++) step();
    set_code(4'd1);
    step();
    chk("kp_pai_row1", PAI, 8'hFB);
    chk("kp_any", key_any, 1'b1);
    set_code(4'd0);
    step();
    chk("kp_pai_row0", PAI, 8'hFF);

    // Bounce rejection
    keys = '0;
    for (int i = 0; i < D + 5; i++) step();
    chk("bnc_idle_any", key_any, 1'b0);
    for (int t = 0; t < 10; t++) begin
      keys[0] = ~keys[0];
      for (int i = 0; i < D / 2; i++) begin
        step();
        chk("bnc_pai", PAI, 8'hFF);
        chk("bnc_any", key_any, 1'b0);
      end
    end
    keys = '0;
    for (int i = 0; i < D + 5; i++) begin
      step();
      chk("bnc_rel_pai", PAI, 8'hFF);
      chk("bnc_rel_any", key_any, 1'b0);
    end

    // Invalid select
    PBO = 8'h1E; DDRA = 8'hFF; PAO = 8'h7F;
    keys = 21'(1) << 9;
    for (int i = 0; i < P + 2; i++) step();
    chk("inv_pre_lit", digit_lit, '0);
    PBO = 8'h02; DDRB = 8'h00;
    step();
    chk("inv_ddrb_pai", PAI, 8'hFF);
    chk("inv_ddrb_lit", digit_lit, '0);
    set_code(4'd3);
    step();
    chk("inv_code3_pai", PAI, 8'hFF);
    chk("inv_code3_lit", digit_lit, '0);
    step();
    chk("inv_code3_lit2", digit_lit, '0);

    // Randomized traffic with occasional reset and slow key changes
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        DDRB = {3'($urandom), 4'hF, 1'($urandom)};
        PBO  = {3'($urandom), 4'($urandom_range(0, 9)), 1'($urandom)};
      end else begin
        DDRB = 8'($urandom);
        PBO  = 8'($urandom);
      end
      PAO  = 8'($urandom);
      DDRA = 8'($urandom);
      if ($urandom_range(0, 47) == 0) keys = 21'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/kim_display_keypad.md
Name: kim_display_keypad

Overview:
- Board-side peripheral model that consumes the RRIOT port outputs (PAO/DDRA, PBO/DDRB) and produces the port A input (PAI), reproducing the KIM-1 7-segment display and 3x7 keypad matrix.
- Decodes the 74145-style select code driven on PB4:1.
- Latches segment data per digit, with a persistence timeout that models LED afterglow.
- Returns debounced keypad row data on PAI for the currently selected row.

Parameters:
- NUM_DIGITS, 6: display digits, served by select codes 4..(3+NUM_DIGITS); maximum 6.
- PERSIST_CYCLES, 4096: phi2 cycles a digit stays lit after its last refresh.
- DEBOUNCE_CYCLES, 1024: phi2 cycles the synchronized key vector must be stable before it is accepted.

Ports:
- phi2  in  1  block clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- PAO  in  8  port A output data.
- DDRA  in  8  port A direction register, 1 = output.
- PBO  in  8  port B output data.
- DDRB  in  8  port B direction register, 1 = output.
- keys  in  21  raw key state, 1 = pressed, asynchronous; key index = row*7 + col.
- PAI  out  8  port A input data, active-low key columns.
- digit_seg  out  NUM_DIGITS*7  segment data; digit d occupies bits [d*7+6:d*7].
- digit_lit  out  NUM_DIGITS  1 = digit currently lit.
- key_any  out  1  OR of the debounced key vector.

Behaviour:
- Reset (rst=1 at edge) has priority over every other event. Reset values:
  - PAI=8'hFF, digit_seg=0, digit_lit=0, key_any=0.
  - Synchronizer flops = 0, debounced vector = 0.
  - All persistence counters = 0, debounce counter = 0.
- Select decode (combinational):
  - sel = PBO[4:1] when DDRB[4:1]==4'hF; otherwise sel = 4'hF (no line active).
  - Codes 0..2 select keypad rows 0..2.
  - Codes 4..(3+NUM_DIGITS) select digits 0..NUM_DIGITS-1.
  - Code 3 and all other codes select nothing.
- Key synchronizer: two flops per bit on keys; the synchronized vector is ksync.
- Debounce:
  - One shared counter; width = clog2(DEBOUNCE_CYCLES+1).
  - If ksync differs from its value in the previous cycle, the counter clears to 0.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES.
  - When the counter equals DEBOUNCE_CYCLES-1 and increments, the debounced vector kdb <= ksync.
  - kdb is updated at most once per stable interval; later cycles at saturation do not reload it.
  - A change lasting fewer than DEBOUNCE_CYCLES consecutive cycles never reaches kdb.
- PAI (registered, 1-cycle latency from sel or kdb):
  - PAI[7] = 1 (TTY idle).
  - For sel = row r in 0..2: PAI[6:0] = ~kdb[r*7+6 : r*7].
  - For any other sel: PAI[6:0] = 7'h7F.
- Display, for each digit d:
  - While sel selects digit d: digit_seg[d] <= PAO[6:0] & DDRA[6:0], counter[d] <= PERSIST_CYCLES, digit_lit[d] <= 1.
  - Otherwise, if counter[d] > 1: decrement.
  - If counter[d] == 1: counter[d] <= 0, digit_lit[d] <= 0, digit_seg[d] <= 0.
  - The blank-out occurs exactly PERSIST_CYCLES edges after the last selecting edge.
  - Re-selecting a digit before timeout reloads its counter; there is no intermediate blank.
  - Only one digit is captured per cycle; unselected digits keep their segment data.
- key_any: registered OR of kdb, one cycle behind kdb.
- Reset mid-operation: lit digits blank immediately and PAI returns to 8'hFF. Held keys re-debounce from zero and reappear DEBOUNCE_CYCLES+3 cycles after rst falls.
- No combinational path from any input to any output.

Test Plan:
- Reset:
  - Stimulus: drive random inputs and assert rst for 2 cycles.
  - Required: PAI=8'hFF, digit_seg=0, digit_lit=0, key_any=0 in the cycle after the first reset edge.
- Digit capture and persistence:
  - Stimulus: DDRB=8'h1E, PBO=8'h08 (code 4), DDRA=8'h7F, PAO=8'h3F for 1 cycle, then PBO=8'h1E.
  - Required: digit_seg[6:0]=7'h3F and digit_lit[0]=1 from the next cycle. digit_lit[0] falls and digit_seg[6:0]=0 exactly PERSIST_CYCLES edges after the capture edge.
- Partial DDRA and refresh:
  - Stimulus: DDRA=8'h0F, PAO=8'h7F, code 5, re-selected every PERSIST_CYCLES-1 cycles for 5 periods.
  - Required: digit_seg[13:7]=7'h0F and digit_lit[1] stays 1 throughout.
- Keypad read:
  - Stimulus: keys[9]=1 (row 1, col 2) held for DEBOUNCE_CYCLES+5 cycles, then DDRB=8'h1E, PBO=8'h02 (code 1).
  - Required: PAI=8'hFB and key_any=1. Changing to code 0 gives PAI=8'hFF.
- Bounce rejection:
  - Stimulus: keys[0] toggled every DEBOUNCE_CYCLES/2 cycles for 10 toggles, then released.
  - Required: kdb stays 0; with code 0 selected, PAI stays 8'hFF and key_any stays 0.
- Invalid select:
  - Stimulus: keys[9] debounced, PBO=8'h02, DDRB=8'h00 (input); then DDRB=8'h1E, PBO=8'h06 (code 3).
  - Required: PAI=8'hFF in both cases, and no digit is captured.
